id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Operand-fetch and ID/EX pipeline register for the MIPS datapath. It sits directly downstream of the 32×32 register file and consumes its two combinational read ports (PA, PB).
- Resolves read-after-write hazards by forwarding from EX/MEM and from the write-back port.
- Detects load-use hazards and stalls the front end.
- Latches operands and control into the ID/EX register that drives the ALU stage.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- REG_W, 5, register-number width
- CNT_W, 16, stall-counter width

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  rising-edge clock, shared with the register file
- Reset  in  1  synchronous, active-high
- PA, PB  in  DATA_W  register-file read data for RA, RB
- RA, RB  in  REG_W  source register numbers of the instruction in ID; also drive the register file RA/RB
- Valid_in  in  1  ID holds a real instruction
- Rw_in  in  REG_W  destination register of the ID instruction
- E_in  in  1  ID instruction writes a register
- Mem_rd_in  in  1  ID instruction is a load
- Imm_in  in  DATA_W  sign-extended immediate
- Flush  in  1  branch/jump redirect; kill the ID instruction
- Exm_rw, Exm_e, Exm_data  in  REG_W/1/DATA_W  EX/MEM destination, write enable, ALU result
- Wb_rw, Wb_e, Wb_data  in  REG_W/1/DATA_W  write-back port; the same nets as register-file RW/E/PW_DS
- Stall  out  1  hold PC and IF/ID (combinational)
- Ex_a, Ex_b, Ex_imm  out  DATA_W  latched operands
- Ex_rw  out  REG_W  latched destination
- Ex_e, Ex_mem_rd, Ex_valid  out  1  latched control
- Stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- **Operand select** (RA shown; RB is identical), first match wins:
  1. RA==0 → 0. Register 0 always reads zero, regardless of register-file contents.
  2. Exm_e & Exm_rw==RA → Exm_data.
  3. Wb_e & Wb_rw==RA → Wb_data. This bypasses the register file's write-then-read-same-cycle gap.
  4. Otherwise → PA.
- **Load-use hazard:** Stall = Valid_in & ~Flush & Ex_valid & Ex_mem_rd & Ex_e & Ex_rw≠0 & (Ex_rw==RA | Ex_rw==RB).
- **ID/EX update each rising edge:**
  - Reset: every output register ← 0 and Stall_count ← 0. Ex_valid=0, Ex_e=0.
  - Flush or Stall: insert a bubble. Ex_valid, Ex_e and Ex_mem_rd ← 0; data fields ← 0.
  - Otherwise: load the selected operands and Imm_in/Rw_in/E_in/Mem_rd_in. Ex_valid ← Valid_in. Ex_e and Ex_mem_rd are ANDed with Valid_in.
- **Stall_count:** increments on each cycle with Stall=1. It saturates at all-ones and never wraps.

## Timing
- Latency: one cycle from ID inputs to the Ex_* outputs.
- Stall is combinational from the current inputs and the current Ex_* state. It is asserted for exactly one cycle per load-use pair, because the bubble clears Ex_mem_rd on the next edge.
- Flush together with Stall: Flush wins. Stall=0 and a bubble is inserted.
- Reset asserted mid-stall: the next edge clears everything, and Stall drops in that cycle because Ex_valid=0.
- Exm and Wb matching the same register: Exm wins as the younger value.
- Exm_e or Wb_e targeting register 0 is never forwarded.

## Structure
- Shared package `mips_pkg`:
  - DATA_W and REG_W constants
  - REG_ZERO = 5'd0
  - `fwd_sel_t` enum {FWD_ZERO, FWD_EXM, FWD_WB, FWD_RF}
- One sub-module, `operand_forward`, instantiated once per operand. Inputs: source register number, register-file data, Exm bundle, Wb bundle. Output: the selected operand (a pure mux).
- Top level holds the hazard logic, the ID/EX register and the counter.

## Test plan
- Reset held for 2 cycles with nonzero inputs → all Ex_* = 0, Stall=0, Stall_count=0.
- RA=3, PA=0x11, Exm_rw=3, Exm_e=1, Exm_data=0x22, Wb_rw=3, Wb_e=1, Wb_data=0x33 → Ex_a=0x22 next cycle. With Exm_e=0 → Ex_a=0x33. With both disabled → Ex_a=0x11.
- RA=0, PA=0xDEAD, Exm_rw=0, Exm_e=1 → Ex_a=0.
- Load to r5 latched (Ex_mem_rd=1, Ex_rw=5), then ID has RB=5, Valid_in=1 → Stall=1 for one cycle, a bubble is latched (Ex_valid=0), and Stall_count=1. The next cycle proceeds with Stall=0.
- Same load-use setup with Flush=1 → Stall=0, bubble latched, Stall_count unchanged.
- Force Stall for 2^16+5 cycles → Stall_count holds at 0xFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and operand-select encoding.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Source of an ID-stage operand, in priority order.
  typedef enum logic [1:0] {
    FWD_ZERO,
    FWD_EXM,
    FWD_WB,
    FWD_RF
  } fwd_sel_t;

endpackage

// File: rtl/operand_forward.sv
// Operand bypass mux: picks r0, EX/MEM, write-back or register-file data.
module operand_forward
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_W  = mips_pkg::REG_W
) (
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [REG_W-1:0]  exm_rw,
  input  logic              exm_e,
  input  logic [DATA_W-1:0] exm_data,
  input  logic [REG_W-1:0]  wb_rw,
  input  logic              wb_e,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand_c
);

  fwd_sel_t sel;

  // Priority select: r0 first, then the younger EX/MEM value, then write-back.
  always_comb begin
    sel = FWD_RF;
    if (src == REG_W'(REG_ZERO)) begin
      sel = FWD_ZERO;
    end else if (exm_e && (exm_rw == src)) begin
      sel = FWD_EXM;
    end else if (wb_e && (wb_rw == src)) begin
      sel = FWD_WB;
    end
  end

  // Data mux driven by the select.
  always_comb begin
    operand_c = rf_data;
    case (sel)
      FWD_ZERO: operand_c = '0;
      FWD_EXM:  operand_c = exm_data;
      FWD_WB:   operand_c = wb_data;
      default:  operand_c = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Operand fetch with forwarding, load-use stall detection and the ID/EX register.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_W  = mips_pkg::REG_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] PA,
  input  logic [DATA_W-1:0] PB,
  input  logic [REG_W-1:0]  RA,
  input  logic [REG_W-1:0]  RB,
  input  logic              Valid_in,
  input  logic [REG_W-1:0]  Rw_in,
  input  logic              E_in,
  input  logic              Mem_rd_in,
  input  logic [DATA_W-1:0] Imm_in,
  input  logic              Flush,
  input  logic [REG_W-1:0]  Exm_rw,
  input  logic              Exm_e,
  input  logic [DATA_W-1:0] Exm_data,
  input  logic [REG_W-1:0]  Wb_rw,
  input  logic              Wb_e,
  input  logic [DATA_W-1:0] Wb_data,
  output logic              Stall,
  output logic [DATA_W-1:0] Ex_a,
  output logic [DATA_W-1:0] Ex_b,
  output logic [DATA_W-1:0] Ex_imm,
  output logic [REG_W-1:0]  Ex_rw,
  output logic              Ex_e,
  output logic              Ex_mem_rd,
  output logic              Ex_valid,
  output logic [CNT_W-1:0]  Stall_count
);

  logic [DATA_W-1:0] op_a_c;
  logic [DATA_W-1:0] op_b_c;
  logic              bubble_c;

  operand_forward #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fwd_a (
    .src       (RA),
    .rf_data   (PA),
    .exm_rw    (Exm_rw),
    .exm_e     (Exm_e),
    .exm_data  (Exm_data),
    .wb_rw     (Wb_rw),
    .wb_e      (Wb_e),
    .wb_data   (Wb_data),
    .operand_c (op_a_c)
  );

  operand_forward #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fwd_b (
    .src       (RB),
    .rf_data   (PB),
    .exm_rw    (Exm_rw),
    .exm_e     (Exm_e),
    .exm_data  (Exm_data),
    .wb_rw     (Wb_rw),
    .wb_e      (Wb_e),
    .wb_data   (Wb_data),
    .operand_c (op_b_c)
  );

  // Load-use hazard: a latched load feeds a source of the ID instruction.
  always_comb begin
    Stall = Valid_in && !Flush && Ex_valid && Ex_mem_rd && Ex_e &&
            (Ex_rw != REG_W'(REG_ZERO)) &&
            ((Ex_rw == RA) || (Ex_rw == RB));
    bubble_c = Flush || Stall;
  end

  // ID/EX pipeline register: bubble on flush/stall, otherwise capture ID.
  always_ff @(posedge Clk) begin
    if (Reset || bubble_c) begin
      Ex_a      <= '0;
      Ex_b      <= '0;
      Ex_imm    <= '0;
      Ex_rw     <= '0;
      Ex_e      <= 1'b0;
      Ex_mem_rd <= 1'b0;
      Ex_valid  <= 1'b0;
    end else begin
      Ex_a      <= op_a_c;
      Ex_b      <= op_b_c;
      Ex_imm    <= Imm_in;
      Ex_rw     <= Rw_in;
      Ex_e      <= E_in && Valid_in;
      Ex_mem_rd <= Mem_rd_in && Valid_in;
      Ex_valid  <= Valid_in;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Stall_count <= '0;
    end else if (Stall && (Stall_count != {CNT_W{1'b1}})) begin
      Stall_count <= Stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 8;

  logic              Clk;
  logic              Reset;
  logic [DATA_W-1:0] PA, PB;
  logic [REG_W-1:0]  RA, RB;
  logic              Valid_in;
  logic [REG_W-1:0]  Rw_in;
  logic              E_in;
  logic              Mem_rd_in;
  logic [DATA_W-1:0] Imm_in;
  logic              Flush;
  logic [REG_W-1:0]  Exm_rw;
  logic              Exm_e;
  logic [DATA_W-1:0] Exm_data;
  logic [REG_W-1:0]  Wb_rw;
  logic              Wb_e;
  logic [DATA_W-1:0] Wb_data;
  logic              Stall;
  logic [DATA_W-1:0] Ex_a, Ex_b, Ex_imm;
  logic [REG_W-1:0]  Ex_rw;
  logic              Ex_e, Ex_mem_rd, Ex_valid;
  logic [CNT_W-1:0]  Stall_count;

  int tests;
  int fails;

  id_ex_stage #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W),
    .CNT_W  (CNT_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PA          (PA),
    .PB          (PB),
    .RA          (RA),
    .RB          (RB),
    .Valid_in    (Valid_in),
    .Rw_in       (Rw_in),
    .E_in        (E_in),
    .Mem_rd_in   (Mem_rd_in),
    .Imm_in      (Imm_in),
    .Flush       (Flush),
    .Exm_rw      (Exm_rw),
    .Exm_e       (Exm_e),
    .Exm_data    (Exm_data),
    .Wb_rw       (Wb_rw),
    .Wb_e        (Wb_e),
    .Wb_data     (Wb_data),
    .Stall       (Stall),
    .Ex_a        (Ex_a),
    .Ex_b        (Ex_b),
    .Ex_imm      (Ex_imm),
    .Ex_rw       (Ex_rw),
    .Ex_e        (Ex_e),
    .Ex_mem_rd   (Ex_mem_rd),
    .Ex_valid    (Ex_valid),
    .Stall_count (Stall_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    PA = '0; PB = '0; RA = '0; RB = '0;
    Valid_in = 1'b0; Rw_in = '0; E_in = 1'b0; Mem_rd_in = 1'b0;
    Imm_in = '0; Flush = 1'b0;
    Exm_rw = '0; Exm_e = 1'b0; Exm_data = '0;
    Wb_rw = '0; Wb_e = 1'b0; Wb_data = '0;
  endtask

  task automatic drive_load_r5();
    Valid_in = 1'b1; Rw_in = 5'd5; E_in = 1'b1; Mem_rd_in = 1'b1;
    RA = 5'd1; RB = 5'd2; PA = 32'h1; PB = 32'h2;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    PA = 32'hAAAA_0001; PB = 32'hBBBB_0002; RA = 5'd3; RB = 5'd4;
    Valid_in = 1'b1; Rw_in = 5'd7; E_in = 1'b1; Mem_rd_in = 1'b1;
    Imm_in = 32'h1234; Exm_rw = 5'd3; Exm_e = 1'b1; Exm_data = 32'h55;
    Wb_rw = 5'd4; Wb_e = 1'b1; Wb_data = 32'h66;
    tick();
    tick();
    tests++;
    if ({Ex_a, Ex_b, Ex_imm} !== '0) begin
      fails++;
      $display("FAIL reset_data: got a=%h b=%h imm=%h, want all 0", Ex_a, Ex_b, Ex_imm);
    end
    tests++;
    if ({Ex_rw, Ex_e, Ex_mem_rd, Ex_valid} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got rw=%0d e=%b mrd=%b v=%b, want 0", Ex_rw, Ex_e, Ex_mem_rd, Ex_valid);
    end
    tests++;
    if (Stall !== 1'b0 || Stall_count !== '0) begin
      fails++;
      $display("FAIL reset_stall: got stall=%b count=%0d, want 0/0", Stall, Stall_count);
    end
    Reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_forward();
    Valid_in = 1'b1; RA = 5'd3; PA = 32'h11; RB = 5'd0; PB = 32'h44;
    Imm_in = 32'h7; Rw_in = 5'd9; E_in = 1'b1; Mem_rd_in = 1'b0;
    Exm_rw = 5'd3; Exm_e = 1'b1; Exm_data = 32'h22;
    Wb_rw = 5'd3; Wb_e = 1'b1; Wb_data = 32'h33;
    tick();
    tests++;
    if (Ex_a !== 32'h22) begin
      fails++;
      $display("FAIL fwd_exm_priority: got %h want 00000022", Ex_a);
    end
    tests++;
    if (Ex_imm !== 32'h7 || Ex_rw !== 5'd9 || Ex_e !== 1'b1 || Ex_valid !== 1'b1 || Ex_mem_rd !== 1'b0) begin
      fails++;
      $display("FAIL latch_ctrl: got imm=%h rw=%0d e=%b v=%b mrd=%b want 7/9/1/1/0",
               Ex_imm, Ex_rw, Ex_e, Ex_valid, Ex_mem_rd);
    end
    tests++;
    if (Ex_b !== 32'h0) begin
      fails++;
      $display("FAIL rb_zero: got %h want 0", Ex_b);
    end
    Exm_e = 1'b0;
    tick();
    tests++;
    if (Ex_a !== 32'h33) begin
      fails++;
      $display("FAIL fwd_wb: got %h want 00000033", Ex_a);
    end
    Wb_e = 1'b0;
    tick();
    tests++;
    if (Ex_a !== 32'h11) begin
      fails++;
      $display("FAIL fwd_rf: got %h want 00000011", Ex_a);
    end
    RB = 5'd7; PB = 32'h44; Wb_rw = 5'd7; Wb_e = 1'b1; Wb_data = 32'h55;
    tick();
    tests++;
    if (Ex_b !== 32'h55 || Ex_a !== 32'h11) begin
      fails++;
      $display("FAIL fwd_b_wb: got a=%h b=%h want 00000011/00000055", Ex_a, Ex_b);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    Valid_in = 1'b1; RA = 5'd0; PA = 32'hDEAD; RB = 5'd0; PB = 32'hBEEF;
    Exm_rw = 5'd0; Exm_e = 1'b1; Exm_data = 32'h99;
    Wb_rw = 5'd0; Wb_e = 1'b1; Wb_data = 32'h77;
    tick();
    tests++;
    if (Ex_a !== 32'h0 || Ex_b !== 32'h0) begin
      fails++;
      $display("FAIL r0_reads_zero: got a=%h b=%h want 0/0", Ex_a, Ex_b);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    drive_load_r5();
    tick();
    tests++;
    if (Ex_mem_rd !== 1'b1 || Ex_rw !== 5'd5 || Stall !== 1'b0) begin
      fails++;
      $display("FAIL load_latch: got mrd=%b rw=%0d stall=%b want 1/5/0", Ex_mem_rd, Ex_rw, Stall);
    end
    Valid_in = 1'b1; RA = 5'd1; RB = 5'd5; Rw_in = 5'd6; Mem_rd_in = 1'b0; E_in = 1'b1;
    #1;
    tests++;
    if (Stall !== 1'b1) begin
      fails++;
      $display("FAIL load_use_stall: got %b want 1", Stall);
    end
    tick();
    tests++;
    if (Ex_valid !== 1'b0 || Ex_e !== 1'b0 || Ex_mem_rd !== 1'b0 || Ex_a !== 32'h0 || Stall_count !== 8'd1) begin
      fails++;
      $display("FAIL load_use_bubble: got v=%b e=%b mrd=%b a=%h cnt=%0d want 0/0/0/0/1",
               Ex_valid, Ex_e, Ex_mem_rd, Ex_a, Stall_count);
    end
    tests++;
    if (Stall !== 1'b0) begin
      fails++;
      $display("FAIL stall_one_cycle: got %b want 0", Stall);
    end
    tick();
    tests++;
    if (Ex_valid !== 1'b1 || Ex_rw !== 5'd6 || Stall_count !== 8'd1) begin
      fails++;
      $display("FAIL load_use_proceed: got v=%b rw=%0d cnt=%0d want 1/6/1", Ex_valid, Ex_rw, Stall_count);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    drive_load_r5();
    tick();
    RB = 5'd5; Mem_rd_in = 1'b0; Rw_in = 5'd6; Flush = 1'b1;
    #1;
    tests++;
    if (Stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_beats_stall: got stall=%b want 0", Stall);
    end
    tick();
    tests++;
    if (Ex_valid !== 1'b0 || Ex_mem_rd !== 1'b0 || Ex_rw !== 5'd0 || Stall_count !== 8'd1) begin
      fails++;
      $display("FAIL flush_bubble: got v=%b mrd=%b rw=%0d cnt=%0d want 0/0/0/1",
               Ex_valid, Ex_mem_rd, Ex_rw, Stall_count);
    end
    idle_inputs();
  endtask

  task automatic test_no_hazard_cases();
    // Load to r0 never stalls.
    drive_load_r5();
    Rw_in = 5'd0;
    tick();
    RA = 5'd0; RB = 5'd0;
    #1;
    tests++;
    if (Stall !== 1'b0) begin
      fails++;
      $display("FAIL load_r0_nostall: got %b want 0", Stall);
    end
    // Invalid ID slot never stalls, and latches disabled control.
    drive_load_r5();
    tick();
    Valid_in = 1'b0; RB = 5'd5;
    #1;
    tests++;
    if (Stall !== 1'b0) begin
      fails++;
      $display("FAIL invalid_nostall: got %b want 0", Stall);
    end
    tick();
    tests++;
    if (Ex_valid !== 1'b0 || Ex_e !== 1'b0 || Ex_mem_rd !== 1'b0) begin
      fails++;
      $display("FAIL invalid_ctrl_masked: got v=%b e=%b mrd=%b want 0/0/0", Ex_valid, Ex_e, Ex_mem_rd);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_stall();
    drive_load_r5();
    tick();
    RB = 5'd5;
    #1;
    tests++;
    if (Stall !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_stall: got %b want 1", Stall);
    end
    Reset = 1'b1;
    tick();
    tests++;
    if (Stall !== 1'b0 || Ex_valid !== 1'b0 || Ex_rw !== 5'd0 || Stall_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_stall: got stall=%b v=%b rw=%0d cnt=%0d want 0/0/0/0",
               Stall, Ex_valid, Ex_rw, Stall_count);
    end
    Reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_saturation();
    // Repeated dependent loads: one stall every two cycles.
    drive_load_r5();
    RB = 5'd5;
    tick();
    for (int i = 1; i <= 260; i++) begin
      tick();
      tick();
      if (i == 10) begin
        tests++;
        if (Stall_count !== 8'd10) begin
          fails++;
          $display("FAIL count_mid: got %0d want 10", Stall_count);
        end
      end
    end
    tests++;
    if (Stall_count !== 8'hFF) begin
      fails++;
      $display("FAIL count_saturate: got %h want ff", Stall_count);
    end
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle_inputs();
    Reset = 1'b1;
    test_reset();
    test_forward();
    test_zero_reg();
    test_load_use();
    test_flush();
    test_no_hazard_cases();
    test_reset_mid_stall();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
